// File: rtl/hzd_scoreboard_unit.sv
// Scoreboard hazard unit for the ID stage: per-register result countdowns for
// multi-cycle producers, divider occupancy, and RAW/WAW/structural stall generation.
module hzd_scoreboard_unit #(
  parameter int NUM_REGS    = 32,
  parameter int LOAD_LAT    = 1,
  parameter int MUL_LAT     = 3,
  parameter int DIV_LAT     = 16,
  parameter int STALL_CNT_W = 32,
  localparam int MAX_LAT    = (LOAD_LAT > MUL_LAT)
                              ? ((LOAD_LAT > DIV_LAT) ? LOAD_LAT : DIV_LAT)
                              : ((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT),
  localparam int CW         = $clog2(MAX_LAT + 1),
  localparam int RW         = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [RW-1:0]          id_rs1,
  input  logic [RW-1:0]          id_rs2,
  input  logic                   id_rs1_used,
  input  logic                   id_rs2_used,
  input  logic [RW-1:0]          id_rd,
  input  logic                   id_reg_write,
  input  logic [1:0]             id_op_class,
  input  logic                   id_flush,
  output logic                   stall,
  output logic                   PCWrite,
  output logic                   div_busy,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    OP_ALU  = 2'd0,
    OP_LOAD = 2'd1,
    OP_MUL  = 2'd2,
    OP_DIV  = 2'd3
  } op_class_e;

  logic [CW-1:0]          cnt_q [NUM_REGS];
  logic [CW-1:0]          cnt_d [NUM_REGS];
  logic [CW-1:0]          div_cnt_q, div_cnt_d;
  logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  op_class_e     op_class;
  logic [CW-1:0] l_new;
  logic          raw, waw, str, issue;

  assign op_class = op_class_e'(id_op_class);

  always_comb begin
    l_new = '0;
    unique case (op_class)
      OP_LOAD: l_new = CW'(LOAD_LAT);
      OP_MUL:  l_new = CW'(MUL_LAT);
      OP_DIV:  l_new = CW'(DIV_LAT);
      default: l_new = '0;
    endcase
  end

  // Single-cycle ALU producers never occupy an entry, so any nonzero count is a real hazard.
  assign raw = (id_rs1_used && (id_rs1 != '0) && (cnt_q[id_rs1] != '0)) ||
               (id_rs2_used && (id_rs2 != '0) && (cnt_q[id_rs2] != '0));
  assign waw = id_reg_write && (id_rd != '0) && (cnt_q[id_rd] > l_new);
  assign str = (op_class == OP_DIV) && div_busy;

  assign stall    = id_valid && !id_flush && (raw || waw || str);
  assign PCWrite  = !stall;
  assign issue    = id_valid && !id_flush && !stall;
  assign div_busy = (div_cnt_q != '0);
  assign stall_cycles = stall_cycles_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CW'(1) : '0;
    end
    cnt_d[0] = '0;
    if (issue && id_reg_write && (id_rd != '0) && (l_new != '0)) begin
      cnt_d[id_rd] = l_new;
    end

    div_cnt_d = (div_cnt_q != '0) ? div_cnt_q - CW'(1) : '0;
    if (issue && (op_class == OP_DIV)) begin
      div_cnt_d = CW'(DIV_LAT);
    end

    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
    end
  end

  // NOTE: the countdown array is flop-based and reset, so the scoreboard always comes up empty;
  // state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      div_cnt_q      <= '0;
      stall_cycles_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      div_cnt_q      <= div_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_hzd_scoreboard_unit.sv
// Directed bench for hzd_scoreboard_unit: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hzd_scoreboard_unit;

  localparam int SCW = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           id_valid = 1'b0;
  logic [4:0]     id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic           id_rs1_used = 1'b0, id_rs2_used = 1'b0, id_reg_write = 1'b0;
  logic [1:0]     id_op_class = '0;
  logic           id_flush = 1'b0;
  logic           stall, PCWrite, div_busy;
  logic [SCW-1:0] stall_cycles;

  typedef struct {
    string          name;
    logic           stall;
    logic           div_busy;
    logic [SCW-1:0] sc;
  } exp_t;

  exp_t           exp_q[$];
  int             n_checks = 0;
  int             n_pass = 0;
  logic [SCW-1:0] sc_model = '0;

  always #5 clk = ~clk;

  hzd_scoreboard_unit #(.STALL_CNT_W(SCW)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_op_class(id_op_class), .id_flush(id_flush),
    .stall(stall), .PCWrite(PCWrite), .div_busy(div_busy), .stall_cycles(stall_cycles)
  );

  task automatic check(input string nm, input string what, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s.%s: got %0h expected %0h (t=%0t)", nm, what, got, exp, $time);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.name, "stall", 32'(stall), 32'(e.stall));
      check(e.name, "PCWrite", 32'(PCWrite), 32'(!e.stall));
      check(e.name, "div_busy", 32'(div_busy), 32'(e.div_busy));
      check(e.name, "stall_cycles", 32'(stall_cycles), 32'(e.sc));
    end
  end

  task automatic drive(input string nm, input bit rst, input bit v, input int cls,
                       input int rd, input bit we, input int rs1, input bit u1,
                       input int rs2, input bit u2, input bit fl,
                       input bit es, input bit eb);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n        = rst;
    id_valid     = v;
    id_op_class  = 2'(cls);
    id_rd        = 5'(rd);
    id_reg_write = we;
    id_rs1       = 5'(rs1);
    id_rs1_used  = u1;
    id_rs2       = 5'(rs2);
    id_rs2_used  = u2;
    id_flush     = fl;
    if (!rst) sc_model = '0;
    e.name = nm; e.stall = es; e.div_busy = eb; e.sc = sc_model;
    exp_q.push_back(e);
    if (rst && es && (sc_model != '1)) sc_model = sc_model + 1'b1;
  endtask

  task automatic ins(input string nm, input int cls, input int rd, input int rs1, input bit u1,
                     input int rs2, input bit u2, input bit es, input bit eb);
    drive(nm, 1'b1, 1'b1, cls, rd, 1'b1, rs1, u1, rs2, u2, 1'b0, es, eb);
  endtask

  task automatic nop(input string nm, input bit eb);
    drive(nm, 1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, eb);
  endtask

  initial begin
    // reset state, then release
    drive("reset", 1'b0, 1'b1, 0, 6, 1'b1, 5, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    nop("post_reset", 1'b0);

    // load-use, LOAD_LAT=1: exactly one bubble
    ins("lu_lw", 1, 5, 0, 0, 0, 0, 1'b0, 1'b0);
    ins("lu_add", 0, 6, 5, 1, 1, 1, 1'b1, 1'b0);
    ins("lu_add", 0, 6, 5, 1, 1, 1, 1'b0, 1'b0);

    // x0 never tracked; unused rs2 ignored
    ins("x0_lw", 1, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    ins("x0_add", 0, 6, 0, 1, 0, 1, 1'b0, 1'b0);
    ins("unused_lw", 1, 5, 0, 0, 0, 0, 1'b0, 1'b0);
    ins("unused_add", 0, 6, 1, 1, 5, 0, 1'b0, 1'b0);

    // three-cycle producer, back-to-back consumer
    ins("mul_dep", 2, 5, 0, 0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) ins("mul_dep_add", 0, 6, 5, 1, 0, 0, 1'b1, 1'b0);
    ins("mul_dep_add", 0, 6, 5, 1, 0, 0, 1'b0, 1'b0);

    // one independent instruction in between shortens the stall by one
    ins("mul_k1", 2, 5, 0, 0, 0, 0, 1'b0, 1'b0);
    ins("mul_k1_indep", 0, 6, 7, 1, 8, 1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) ins("mul_k1_add", 0, 6, 5, 1, 0, 0, 1'b1, 1'b0);
    ins("mul_k1_add", 0, 6, 5, 1, 0, 0, 1'b0, 1'b0);

    // WAW: load behind mul to x9 waits until cnt is no longer greater than LOAD_LAT
    ins("waw_mul", 2, 9, 0, 0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) ins("waw_lw", 1, 9, 0, 0, 0, 0, 1'b1, 1'b0);
    ins("waw_lw", 1, 9, 0, 0, 0, 0, 1'b0, 1'b0);
    ins("waw_lw_use", 0, 6, 9, 1, 0, 0, 1'b1, 1'b0);
    ins("waw_lw_use", 0, 6, 9, 1, 0, 0, 1'b0, 1'b0);
    ins("raw_mul9", 2, 9, 0, 0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) ins("raw_mul9_add", 0, 6, 9, 1, 0, 0, 1'b1, 1'b0);
    ins("raw_mul9_add", 0, 6, 9, 1, 0, 0, 1'b0, 1'b0);
    ins("waw_alu_mul", 2, 10, 0, 0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) ins("waw_alu", 0, 10, 0, 0, 0, 0, 1'b1, 1'b0);
    ins("waw_alu", 0, 10, 0, 0, 0, 0, 1'b0, 1'b0);

    // flush overrides a RAW stall and leaves counters alone
    ins("fl_mul", 2, 5, 0, 0, 0, 0, 1'b0, 1'b0);
    drive("fl_add", 1'b1, 1'b1, 0, 6, 1'b1, 5, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) ins("fl_after", 0, 6, 5, 1, 0, 0, 1'b1, 1'b0);
    ins("fl_after", 0, 6, 5, 1, 0, 0, 1'b0, 1'b0);
    drive("fl_div", 1'b1, 1'b1, 3, 7, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive("fl_mul11", 1'b1, 1'b1, 2, 11, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    ins("fl_use11", 0, 6, 11, 1, 0, 0, 1'b0, 1'b0);

    // divider occupancy, then RAW on a divide result; stall counter saturates at 31
    ins("div7", 3, 7, 0, 0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) ins("div8_str", 3, 8, 0, 0, 0, 0, 1'b1, 1'b1);
    ins("div8_str", 3, 8, 0, 0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) ins("div8_raw", 0, 6, 8, 1, 0, 0, 1'b1, 1'b1);
    ins("div8_raw", 0, 6, 8, 1, 0, 0, 1'b0, 1'b0);

    // reset mid-divide discards everything at once
    ins("rst_div3", 3, 3, 0, 0, 0, 0, 1'b0, 1'b0);
    nop("rst_busy", 1'b1);
    drive("rst_mid", 1'b0, 1'b1, 0, 6, 1'b1, 3, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    ins("rst_after", 0, 6, 3, 1, 0, 0, 1'b0, 1'b0);
    ins("rst_lw", 1, 5, 0, 0, 0, 0, 1'b0, 1'b0);
    ins("rst_lu", 0, 6, 5, 1, 0, 0, 1'b1, 1'b0);
    nop("rst_end", 1'b0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
